// File: rtl/bcd_display_pkg.sv
// Shared constants and types for the multiplexed BCD 7-segment scanner.
// Segment patterns are active-low with bit 0 = segment a ... bit 6 = segment g.
package bcd_display_pkg;

  localparam int NUM_DIGITS = 9;
  localparam int IDX_W      = 4;

  typedef logic [3:0]       bcd_t;
  typedef logic [6:0]       seg_t;
  typedef logic [IDX_W-1:0] idx_t;

  localparam seg_t SEG_0    = 7'b1000000;
  localparam seg_t SEG_1    = 7'b1111001;
  localparam seg_t SEG_2    = 7'b0100100;
  localparam seg_t SEG_3    = 7'b0110000;
  localparam seg_t SEG_4    = 7'b0011001;
  localparam seg_t SEG_5    = 7'b0010010;
  localparam seg_t SEG_6    = 7'b0000010;
  localparam seg_t SEG_7    = 7'b1111000;
  localparam seg_t SEG_8    = 7'b0000000;
  localparam seg_t SEG_9    = 7'b0010000;
  localparam seg_t SEG_DASH = 7'b0111111;
  localparam seg_t SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes show '-'.
module bcd_to_seg7
  import bcd_display_pkg::*;
(
  input  bcd_t bcd,
  output seg_t seg_n
);

  // Map one BCD code to its segment pattern.
  always_comb begin
    case (bcd)
      4'd0:    seg_n = SEG_0;
      4'd1:    seg_n = SEG_1;
      4'd2:    seg_n = SEG_2;
      4'd3:    seg_n = SEG_3;
      4'd4:    seg_n = SEG_4;
      4'd5:    seg_n = SEG_5;
      4'd6:    seg_n = SEG_6;
      4'd7:    seg_n = SEG_7;
      4'd8:    seg_n = SEG_8;
      4'd9:    seg_n = SEG_9;
      default: seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Nine-digit multiplexed common-anode display driver. Digits are snapshotted
// only at the frame wrap so a frame never mixes old and new values; each slot
// opens with an all-anodes-off interval to suppress ghosting.
module bcd_display_scanner
  import bcd_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  load,
  input  logic                  blank_zero,
  input  logic [3:0]            BCD0,
  input  logic [3:0]            BCD1,
  input  logic [3:0]            BCD2,
  input  logic [3:0]            BCD3,
  input  logic [3:0]            BCD4,
  input  logic [3:0]            BCD5,
  input  logic [3:0]            BCD6,
  input  logic [3:0]            BCD7,
  input  logic [3:0]            BCD8,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic [6:0]            seg_n,
  output logic                  frame_start
);

  localparam int unsigned           CNT_W     = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]      CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam idx_t                  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE    = NUM_DIGITS'(1);
  localparam logic [NUM_DIGITS-1:0] MASK_RST  = {{(NUM_DIGITS-1){1'b1}}, 1'b0};

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  idx_t                  idx_q, idx_d;
  logic                  pending_q, pending_d;
  bcd_t                  snap_q [NUM_DIGITS];
  bcd_t                  snap_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  seg_t                  seg_n_q, seg_n_d;
  logic                  frame_start_q, frame_start_d;

  bcd_t                  bcd_in [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] mask_new;
  logic                  all_zero;
  logic                  tick;
  logic                  wrap;
  logic                  capture;
  seg_t                  seg_dec;

  assign bcd_in[0] = BCD0;
  assign bcd_in[1] = BCD1;
  assign bcd_in[2] = BCD2;
  assign bcd_in[3] = BCD3;
  assign bcd_in[4] = BCD4;
  assign bcd_in[5] = BCD5;
  assign bcd_in[6] = BCD6;
  assign bcd_in[7] = BCD7;
  assign bcd_in[8] = BCD8;

  // Single shared decoder, fed by the digit currently being scanned.
  bcd_to_seg7 u_dec (
    .bcd   (snap_q[idx_q]),
    .seg_n (seg_dec)
  );

  // Leading-zero mask from the live inputs: digit i blanks when it and every
  // more significant digit are zero; digit 0 always stays lit.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a value on
    // every path first, otherwise synthesis infers a latch to hold it.
    mask_new = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero    = all_zero & (bcd_in[i] == 4'd0);
      mask_new[i] = (i != 0) && blank_zero && all_zero;
    end
  end

  // Next-state logic: prescaler, slot index, snapshot request and outputs.
  always_comb begin
    tick    = (cnt_q == CNT_LAST);
    wrap    = tick && (idx_q == IDX_LAST);
    capture = wrap && (pending_q || load);

    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    // A load on the capture cycle is served by that capture itself.
    pending_d = capture ? 1'b0 : (pending_q || load);

    snap_d = snap_q;
    mask_d = mask_q;
    if (capture) begin
      snap_d = bcd_in;
      mask_d = mask_new;
    end

    an_n_d  = '1;
    seg_n_d = SEG_OFF;
    if (cnt_q >= CNT_BLANK) begin
      an_n_d  = ~(AN_ONE << idx_q);
      seg_n_d = mask_q[idx_q] ? SEG_OFF : seg_dec;
    end

    frame_start_d = wrap;
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      pending_q     <= 1'b0;
      // NOTE: the snapshot is reset because its contents are visible on the
      // display straight out of reset, not merely internal scratch storage.
      for (int i = 0; i < NUM_DIGITS; i++) snap_q[i] <= '0;
      mask_q        <= MASK_RST;
      an_n_q        <= '1;
      seg_n_q       <= SEG_OFF;
      frame_start_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values,
      // so ordering of statements here cannot change behaviour.
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      snap_q        <= snap_d;
      mask_q        <= mask_d;
      an_n_q        <= an_n_d;
      seg_n_q       <= seg_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an_n        = an_n_q;
  assign seg_n       = seg_n_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with SCAN_DIV=8, BLANK_CYCLES=2.
// Time is tracked as rising edges since reset release (n). The outputs after
// edge n reflect the state before it: cnt=(n-1)%8, slot=((n-1)/8)%9. So slot s
// of frame f is lit at edge 72f+8s+5, and a capture happens at edge 72f.
module tb_bcd_display_scanner;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       load = 1'b0;
  logic       blank_zero = 1'b1;
  logic [3:0] d [9];
  logic [8:0] an_n;
  logic [6:0] seg_n;
  logic       frame_start;

  int vectors = 0;
  int miscompares = 0;
  int edges = 0;

  bcd_display_scanner #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .load        (load),
    .blank_zero  (blank_zero),
    .BCD0        (d[0]),
    .BCD1        (d[1]),
    .BCD2        (d[2]),
    .BCD3        (d[3]),
    .BCD4        (d[4]),
    .BCD5        (d[5]),
    .BCD6        (d[6]),
    .BCD7        (d[7]),
    .BCD8        (d[8]),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .frame_start (frame_start)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after rising edge n (counted from reset release).
  task automatic run_to(input int n);
    while (edges < n) begin
      @(posedge Clk);
      edges++;
    end
    #1;
  endtask

  // Digits as nine hex nibbles, BCD8 in the top nibble.
  task automatic set_digits(input logic [35:0] v);
    for (int i = 0; i < 9; i++) d[i] = v[4*i +: 4];
  endtask

  task automatic release_reset();
    @(negedge Clk);
    Reset = 1'b0;
    edges = 0;
  endtask

  task automatic pulse_load(input int at_edge);
    run_to(at_edge);
    load = 1'b1;
    run_to(at_edge + 1);
    load = 1'b0;
  endtask

  initial begin
    set_digits(36'h000000000);

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    check("rst_an", 16'(an_n), 16'h1FF);
    check("rst_seg", 16'(seg_n), 16'h7F);
    check("rst_fs", 16'(frame_start), 16'h0);
    release_reset();

    // Idle after reset: only digit 0 shows '0', rest blanked
    run_to(2);  check("idle_blank_an", 16'(an_n), 16'h1FF);
    run_to(3);  check("idle_s0_an", 16'(an_n), 16'h1FE);
                check("idle_s0_seg", 16'(seg_n), 16'h40);
    run_to(13); check("idle_s1_an", 16'(an_n), 16'h1FD);
                check("idle_s1_seg", 16'(seg_n), 16'h7F);
    run_to(69); check("idle_s8_an", 16'(an_n), 16'h0FF);
                check("idle_s8_seg", 16'(seg_n), 16'h7F);
    run_to(71); check("fs_pre", 16'(frame_start), 16'h0);
    run_to(72); check("fs_72", 16'(frame_start), 16'h1);
    run_to(73); check("fs_post", 16'(frame_start), 16'h0);
    run_to(144); check("fs_144", 16'(frame_start), 16'h1);

    // 650345768 with one load pulse; captured at edge 216
    set_digits(36'h650345768);
    pulse_load(144);
    run_to(149); check("pre_cap_s0", 16'(seg_n), 16'h40);
    run_to(221); check("b_s0_an", 16'(an_n), 16'h1FE);
                 check("b_s0_seg", 16'(seg_n), 16'h00);
    run_to(237); check("b_s2_seg", 16'(seg_n), 16'h78);
    run_to(269); check("b_s6_an", 16'(an_n), 16'h1BF);
                 check("b_s6_seg", 16'(seg_n), 16'h40);
    run_to(285); check("b_s8_an", 16'(an_n), 16'h0FF);
                 check("b_s8_seg", 16'(seg_n), 16'h02);

    // 001234593 with blanking; captured at edge 288
    set_digits(36'h001234593);
    pulse_load(285);
    run_to(301); check("c_s1_seg", 16'(seg_n), 16'h10);
    run_to(341); check("c_s6_seg", 16'(seg_n), 16'h79);
    run_to(349); check("c_s7_an", 16'(an_n), 16'h17F);
                 check("c_s7_blank", 16'(seg_n), 16'h7F);
    run_to(357); check("c_s8_blank", 16'(seg_n), 16'h7F);

    // Same digits, blanking off; captured at edge 360
    blank_zero = 1'b0;
    pulse_load(357);
    run_to(421); check("c_s7_zero", 16'(seg_n), 16'h40);
    run_to(429); check("c_s8_zero", 16'(seg_n), 16'h40);

    // Inputs change without load: display holds for three frames
    set_digits(36'h888888888);
    blank_zero = 1'b1;
    run_to(461); check("hold_s3", 16'(seg_n), 16'h19);
    run_to(565); check("hold_s7", 16'(seg_n), 16'h40);
    run_to(581); check("hold_s0", 16'(seg_n), 16'h30);
    run_to(645); check("hold_s8", 16'(seg_n), 16'h40);

    // Non-decimal code in BCD3; captured at edge 648
    set_digits(36'h00000C000);
    pulse_load(645);
    run_to(669); check("e_s2_seg", 16'(seg_n), 16'h40);
    run_to(677); check("e_s3_an", 16'(an_n), 16'h1F7);
                 check("e_s3_dash", 16'(seg_n), 16'h3F);
    run_to(685); check("e_s4_blank", 16'(seg_n), 16'h7F);

    // Pending request, then reset inside slot 5 blank interval
    set_digits(36'h777777777);
    pulse_load(730);
    run_to(761);
    #2 Reset = 1'b1;
    #1;
    check("f_rst_an", 16'(an_n), 16'h1FF);
    check("f_rst_seg", 16'(seg_n), 16'h7F);
    check("f_rst_fs", 16'(frame_start), 16'h0);
    repeat (2) @(posedge Clk);
    release_reset();
    run_to(2);  check("f_blank_an", 16'(an_n), 16'h1FF);
    run_to(5);  check("f_s0_an", 16'(an_n), 16'h1FE);
                check("f_s0_seg", 16'(seg_n), 16'h40);
    run_to(61); check("f_s7_seg", 16'(seg_n), 16'h7F);
    run_to(72); check("f_fs_72", 16'(frame_start), 16'h1);
    run_to(77); check("f_no_pending", 16'(seg_n), 16'h40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

Multiplexed 7-segment display driver for the nine BCD digits (BCD0 = least significant … BCD8) produced by the binary-to-BCD converter. It snapshots a coherent digit set only at frame boundaries and scans one digit per slot with a programmable slot length. It applies leading-zero blanking and inserts an anti-ghosting blank interval at the start of each slot. It sits directly downstream of the converter and drives the board's common-anode display pins.

## Interface
- SCAN_DIV, 50000: clocks per digit slot; legal range ≥ 2.
- BLANK_CYCLES, 500: clocks at the start of each slot with all anodes off; legal range 0 ≤ BLANK_CYCLES < SCAN_DIV.
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- load  in  1  request a digit snapshot; sampled every rising edge.
- blank_zero  in  1  enable leading-zero blanking; evaluated at snapshot time.
- BCD0..BCD8  in  4 each  digit inputs; BCD0 is least significant.
- an_n  out  9  digit enables, active-low, one-hot-low; bit i selects BCDi.
- seg_n  out  7  segments, active-low; seg_n[0]=a … seg_n[6]=g.
- frame_start  out  1  one-cycle pulse when slot index wraps to 0.

## Operation
- Prescaler cnt: counts 0..SCAN_DIV-1. tick = (cnt == SCAN_DIV-1). On tick, cnt returns to 0.
- Slot index idx: range 0..8. On tick, idx advances by 1; it wraps 8→0.
- pending flag:
  - Set by load=1.
  - Cleared when a capture occurs.
  - load=1 on the capture cycle itself also counts, so no request is lost.
- Capture:
  - Occurs on a tick with idx==8, if pending or load is set.
  - snap[0..8] ← BCD0..BCD8.
  - blank mask ← computed from the new inputs.
  - Without a capture, snap holds its value indefinitely.
- Blank mask:
  - Digit i (i ≥ 1) is blanked iff blank_zero=1 and BCDi..BCD8 are all zero at capture.
  - Digit 0 is never blanked.
- Decode:
  - 0–9 use standard patterns, e.g. 0 → 7'b1000000, 8 → 7'b0000000.
  - Codes 10–15 display '-' (7'b0111111).
  - A blanked digit displays 7'b1111111.
- Output register, updated every edge:
  - If cnt < BLANK_CYCLES: an_n ← all ones, seg_n ← all ones.
  - Otherwise: an_n ← ~(1 << idx), seg_n ← decode(snap[idx]) or blank.
- frame_start is registered. It is 1 for exactly the cycle after each tick with idx==8.

## Timing
- Reset values: cnt=0, idx=0, pending=0, snap all 0, mask all blanked except digit 0. Outputs: an_n=9'h1FF, seg_n=7'h7F, frame_start=0.
- Outputs lag (cnt, idx, snap) by one clock.
- After Reset deasserts, an_n[0] first goes low BLANK_CYCLES+1 edges later.
- Frame period = 9·SCAN_DIV clocks.
- Capture-to-display latency:
  - New digits become visible in the slot-0 window that starts one clock after the capturing tick.
  - Worst case from load to visible is 9·SCAN_DIV + BLANK_CYCLES + 1 clocks.
- Changes on BCDx between captures never affect outputs, so there is no tearing within a frame.
- Reset asserted mid-frame forces reset values immediately, regardless of clock. Scanning restarts from slot 0 and any pending request is discarded.
- BLANK_CYCLES=0: no blank interval. The anode switches directly between digits on the same edge as the segment data.

## Structure
- Package bcd_display_pkg holds:
  - NUM_DIGITS=9.
  - Segment pattern constants SEG_0..SEG_9, SEG_DASH and SEG_OFF (active-low).
  - The digit index width (4).
- Sub-module bcd_to_seg7: purely combinational 4-bit → 7-bit active-low decoder, one instance muxed by idx.
- Prescaler, idx, pending/capture logic and the output register stay in the top module.

## Test plan
Run with SCAN_DIV=8, BLANK_CYCLES=2.
- Reset then idle, blank_zero=1:
  - Slot 0 shows seg_n=7'b1000000, an_n=9'h1FE.
  - Slots 1–8 show seg_n=7'h7F.
  - frame_start pulses every 72 clocks.
- Digits 650345768, load pulsed once, blank_zero=1:
  - After the next frame wrap, slot 8 shows '6' (7'b0000010) and slot 0 shows '8'.
  - No digit is blanked.
- Digits 001234593, blank_zero=1, then 0:
  - With blank_zero=1, slots 7–8 are blank.
  - With blank_zero=0 and a reload, slots 7–8 show '0'.
- BCD inputs changed mid-frame with load=0:
  - Outputs are unchanged for ≥ 3 frames.
- BCD3 = 4'hC captured → slot 3 shows 7'b0111111.
- Reset asserted during slot 5 blank interval:
  - Outputs read 9'h1FF / 7'h7F on the same cycle.
  - snap is zeroed and pending is cleared.
  - Scanning resumes at slot 0.
